// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer:
// LEGv8 ALU function-select encodings and the sequencer state encoding.
package alu_mul_sequencer_pkg;

    localparam int FS_W = 5;

    localparam logic [FS_W-1:0] FS_AND  = 5'b00000;
    localparam logic [FS_W-1:0] FS_OR   = 5'b00100;
    localparam logic [FS_W-1:0] FS_ADD  = 5'b01000;
    localparam logic [FS_W-1:0] FS_XOR  = 5'b01100;
    localparam logic [FS_W-1:0] FS_SHL  = 5'b10000;
    localparam logic [FS_W-1:0] FS_SHR  = 5'b10100;
    // Operand inversion modifiers, OR-ed onto a base operation
    localparam logic [FS_W-1:0] FS_AINV = 5'b00001;
    localparam logic [FS_W-1:0] FS_BINV = 5'b00010;

    // Index of the carry flag inside the ALU {V,C,N,Z} status word
    localparam int STATUS_C_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ADD   = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/result handshake plus the shared-ALU operand/result bus of the
// multiply sequencer. slave = sequencer side, master = requester/ALU side.
interface alu_mul_sequencer_if
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             ovf;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [FS_W-1:0]  alu_fs;
    logic             alu_c0;
    logic [WIDTH-1:0] alu_f;
    logic [3:0]       alu_status;

    modport slave (
        input  start, a, b, alu_f, alu_status,
        output busy, done, product, ovf, alu_a, alu_b, alu_fs, alu_c0
    );

    modport master (
        output start, a, b, alu_f, alu_status,
        input  busy, done, product, ovf, alu_a, alu_b, alu_fs, alu_c0
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned multiplier that borrows the external LEGv8 ALU for one
// ADD or shift-left per cycle. Define ALU_MUL_EARLY_EXIT_EN to stop shifting
// once no multiplier bits remain.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                clock,
    input  logic                reset,
    alu_mul_sequencer_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] p_reg;
    logic [CW-1:0]    count_reg;
    logic             ovf_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] product_reg;
    logic             ovf_out_reg;

    logic [WIDTH-1:0] q_shr;
    logic             shift_ovf;
    logic             last_shift;
    logic             skip_work;
    logic             unused_status;

    assign q_shr = q_reg >> 1;
    // The bit leaving M is lost; that only matters if a later ADD would use it.
    assign shift_ovf = m_reg[WIDTH-1] & (q_shr != '0);
    assign unused_status = ^{bus.alu_status[3], bus.alu_status[1:0]};

`ifdef ALU_MUL_EARLY_EXIT_EN
    assign last_shift = (count_reg == CW'(WIDTH - 1)) || (q_shr == '0);
    assign skip_work  = (bus.b == '0);
`else
    assign last_shift = (count_reg == CW'(WIDTH - 1));
    assign skip_work  = 1'b0;
`endif

    always_comb begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_fs = FS_AND;
        bus.alu_c0 = 1'b0;
        case (state_reg)
            ST_ADD: begin
                bus.alu_a  = p_reg;
                bus.alu_b  = m_reg;
                bus.alu_fs = FS_ADD;
            end
            ST_SHIFT: begin
                bus.alu_a  = m_reg;
                bus.alu_b  = WIDTH'(1);
                bus.alu_fs = FS_SHL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            m_reg       <= '0;
            q_reg       <= '0;
            p_reg       <= '0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
            ovf_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        m_reg     <= bus.a;
                        q_reg     <= bus.b;
                        p_reg     <= '0;
                        count_reg <= '0;
                        ovf_reg   <= 1'b0;
                        if (skip_work) begin
                            state_reg   <= ST_DONE;
                            done_reg    <= 1'b1;
                            product_reg <= '0;
                            ovf_out_reg <= 1'b0;
                        end else begin
                            state_reg <= bus.b[0] ? ST_ADD : ST_SHIFT;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_ADD: begin
                    p_reg     <= bus.alu_f;
                    ovf_reg   <= ovf_reg | bus.alu_status[STATUS_C_BIT];
                    state_reg <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    m_reg     <= bus.alu_f;
                    q_reg     <= q_shr;
                    count_reg <= count_reg + CW'(1);
                    if (shift_ovf) begin
                        ovf_reg <= 1'b1;
                    end
                    // P is final here: the last operation of a run is always a shift
                    if (last_shift) begin
                        state_reg   <= ST_DONE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        product_reg <= p_reg;
                        ovf_out_reg <= ovf_reg | shift_ovf;
                    end else begin
                        state_reg <= q_reg[1] ? ST_ADD : ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = product_reg;
    assign bus.ovf     = ovf_out_reg;

endmodule
